// File: rtl/shared_gate_scheduler_if.sv
// ---------------------------------------------------------------------------
// shared_gate_scheduler_if
// Bundles the requester-side and consumer-side handshake of the shared gate
// scheduler.
//   req_valid [N_REQ]    : per-requester request valid        (master -> slave)
//   req_ready [N_REQ]    : per-requester one-cycle accept     (slave -> master)
//   req_op    [2*N_REQ]  : opcode of requester i at [2i+1:2i] (master -> slave)
//   req_a/b   [W*N_REQ]  : operands of requester i at [W*i+W-1:W*i]
//   rsp_valid            : result valid                       (slave -> master)
//   rsp_ready            : consumer accepts result            (master -> slave)
//   rsp_id    [log2 N]   : requester that owns the result     (slave -> master)
//   rsp_data  [W]        : result                             (slave -> master)
// ---------------------------------------------------------------------------
interface shared_gate_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [2*N_REQ-1:0] req_op;
  logic [W*N_REQ-1:0] req_a;
  logic [W*N_REQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [W-1:0]       rsp_data;

  // Requesters and result consumer side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shared_gate_scheduler.sv
// ---------------------------------------------------------------------------
// shared_gate_scheduler
// Time-shares one W-bit bitwise logic unit between N_REQ requesters.
// A round-robin arbiter picks one requester in IDLE, the operands are latched,
// the result is computed and registered in EXEC, and HOLD presents it until
// the consumer takes it. Only one request is in flight at any time.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : shared_gate_scheduler_if.slave (request / response handshake)
// ---------------------------------------------------------------------------
module shared_gate_scheduler #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shared_gate_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Shared logic unit: each result bit is a single 2:1 mux selected by b,
  // choosing between a, ~a or a constant depending on the opcode.
  function automatic logic [W-1:0] gate_unit(
    input logic [1:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] y;
    y = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      case (op)
        2'b00:   y[i] = b[i] ? a[i]  : 1'b0;  // AND
        2'b01:   y[i] = b[i] ? 1'b1  : a[i];  // OR
        2'b10:   y[i] = b[i] ? ~a[i] : a[i];  // XOR
        2'b11:   y[i] = b[i] ? ~a[i] : 1'b1;  // NAND
        default: y[i] = 1'b0;
      endcase
    end
    return y;
  endfunction

  state_t            state_r;
  logic [ID_W-1:0]   last_grant_r;
  logic [ID_W-1:0]   g_r;
  logic [1:0]        op_r;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [W-1:0]      rsp_data_r;
  // Cleared by reset and set by the first clock edge afterwards, so no grant
  // can be offered while in reset or before the first edge after release.
  logic              run_r;

  logic              found_s;
  logic [ID_W-1:0]   grant_s;
  logic              accept_s;
  logic [N_REQ-1:0]  ready_s;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin : rr_arbiter
    int idx;
    found_s = 1'b0;
    grant_s = {ID_W{1'b0}};
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(last_grant_r) + 32'sd1 + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && bus.req_valid[idx]) begin
        found_s = 1'b1;
        grant_s = ID_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign accept_s = (state_r == IDLE) && run_r && found_s;

  // One-hot accept strobe; the chosen requester is valid by construction,
  // so ready and valid coincide and the transfer happens this cycle.
  always_comb begin
    ready_s = {N_REQ{1'b0}};
    if (accept_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
  end

  // Control FSM with operand latch and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= ID_W'(N_REQ - 1);
      g_r          <= {ID_W{1'b0}};
      op_r         <= 2'b00;
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {ID_W{1'b0}};
      rsp_data_r   <= {W{1'b0}};
      run_r        <= 1'b0;
    end else begin
      run_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r         <= bus.req_op[2*grant_s +: 2];
            a_r          <= bus.req_a[W*grant_s +: W];
            b_r          <= bus.req_b[W*grant_s +: W];
            g_r          <= grant_s;
            last_grant_r <= grant_s;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          rsp_data_r  <= gate_unit(op_r, a_r, b_r);
          rsp_id_r    <= g_r;
          rsp_valid_r <= 1'b1;
          state_r     <= HOLD;
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_shared_gate_scheduler.sv
// ---------------------------------------------------------------------------
// tb_shared_gate_scheduler
// Self-checking bench: a cycle model of the scheduler predicts req_ready and
// rsp_valid every cycle and pushes expected responses into a scoreboard queue
// at acceptance; responses are popped and compared when they transfer.
// A vector table covers the opcodes, plus hand-written round-robin,
// backpressure, reset-mid-operation and random sequences.
// ---------------------------------------------------------------------------
module tb_shared_gate_scheduler;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = $clog2(N);

  typedef enum int {M_IDLE, M_EXEC, M_HOLD} mstate_t;

  typedef struct {
    int         req;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  shared_gate_scheduler_if #(.N_REQ(N), .W(W)) bus ();

  shared_gate_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  mstate_t        m_state;
  logic [IDW-1:0] m_last;
  logic           m_run;
  rsp_t           sb_q[$];
  int             wait_cnt[N];

  logic [N-1:0]   seen_ready;
  logic           seen_rsp;
  logic [IDW-1:0] seen_id;
  logic [W-1:0]   seen_data;

  vec_t tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_gate(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input logic [IDW-1:0] last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, then
  // return 1 ns after the rising edge so the caller can drive new inputs.
  task automatic step();
    logic [N-1:0] exp_ready;
    int g;
    int dg;
    rsp_t r;
    @(negedge clk);
    g = (m_state == M_IDLE && m_run) ? rr_pick(bus.req_valid, m_last) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    seen_ready = bus.req_ready;
    seen_rsp   = bus.rsp_valid;
    seen_id    = bus.rsp_id;
    seen_data  = bus.rsp_data;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_state == M_HOLD));
    if (m_state == M_HOLD && sb_q.size() > 0) begin
      check("rsp_id", 32'(bus.rsp_id), 32'(sb_q[0].id));
      check("rsp_data", 32'(bus.rsp_data), 32'(sb_q[0].data));
    end
    // Fairness measured on the DUT's own grants.
    dg = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[i]) dg = i;
    if (dg >= 0) begin
      for (int i = 0; i < N; i++) begin
        if (i == dg) begin
          check("starve_wait", 32'(wait_cnt[i] < N), 32'd1);
          wait_cnt[i] = 0;
        end else if (bus.req_valid[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) if (!bus.req_valid[i]) wait_cnt[i] = 0;
    case (m_state)
      M_IDLE: if (g >= 0) begin
        r.id   = IDW'(g);
        r.data = ref_gate(bus.req_op[2*g +: 2], bus.req_a[W*g +: W], bus.req_b[W*g +: W]);
        sb_q.push_back(r);
        m_last  = IDW'(g);
        m_state = M_EXEC;
      end
      M_EXEC: m_state = M_HOLD;
      default: if (bus.rsp_ready) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        m_state = M_IDLE;
      end
    endcase
    m_run = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs clear with no clock edge, release.
  task automatic apply_reset(input logic [N-1:0] v);
    rst_n = 1'b0;
    bus.req_valid = v;
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_state = M_IDLE;
    m_last  = IDW'(N - 1);
    m_run   = 1'b0;
    sb_q.delete();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] exp_oh;
    int gc;
    int last_gc;
    int k;
    bit done;

    tab[0] = '{0, 2'b00, 8'hF0, 8'h3C, 8'h30};
    tab[1] = '{1, 2'b00, 8'hA5, 8'h0F, 8'h05};
    tab[2] = '{2, 2'b01, 8'hA5, 8'h0F, 8'hAF};
    tab[3] = '{3, 2'b10, 8'hA5, 8'h0F, 8'hAA};
    tab[4] = '{0, 2'b11, 8'hA5, 8'h0F, 8'hFA};
    tab[5] = '{1, 2'b10, 8'hFF, 8'h00, 8'hFF};
    tab[6] = '{2, 2'b11, 8'h00, 8'h00, 8'hFF};
    tab[7] = '{3, 2'b01, 8'h00, 8'h00, 8'h00};

    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #2;
    apply_reset(4'b1111);

    // Table-driven single requests, consumer always ready.
    for (int t = 0; t < 8; t++) begin
      bus.req_op = '1;
      bus.req_a  = '1;
      bus.req_b  = '1;
      bus.req_op[2*tab[t].req +: 2] = tab[t].op;
      bus.req_a[W*tab[t].req +: W]  = tab[t].a;
      bus.req_b[W*tab[t].req +: W]  = tab[t].b;
      v = '0;
      v[tab[t].req] = 1'b1;
      bus.req_valid = v;
      bus.rsp_ready = 1'b1;
      gc   = -100;
      done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
        step();
        if (seen_ready != '0) begin
          gc = c;
          bus.req_valid = '0;
        end
        if (seen_rsp) begin
          check("vec_id", 32'(seen_id), 32'(tab[t].req));
          check("vec_data", 32'(seen_data), 32'(tab[t].exp_data));
          check("vec_latency", 32'(c - gc), 32'd2);
          done = 1'b1;
        end
      end
      check("vec_done", 32'(done), 32'd1);
    end

    // Round-robin with all requesters held valid after reset.
    apply_reset(4'b0000);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    last_gc = -1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      bus.req_a = 32'($urandom);
      bus.req_b = 32'($urandom);
      bus.req_op = 8'($urandom);
      step();
      if (seen_ready != '0) begin
        exp_oh = '0;
        exp_oh[k % N] = 1'b1;
        check("rr_order", 32'(seen_ready), 32'(exp_oh));
        if (last_gc >= 0) check("rr_period", 32'(c - last_gc), 32'd3);
        last_gc = c;
        k++;
      end
    end
    check("rr_count", 32'(k >= 12), 32'd1);

    // Backpressure: hold the result for 5 cycles with others requesting.
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    bus.req_op[2*2 +: 2] = 2'b10;
    bus.req_a[W*2 +: W]  = 8'h3C;
    bus.req_b[W*2 +: W]  = 8'hFF;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      step();
      if (seen_ready != '0) bus.req_valid = '0;
      if (seen_rsp) done = 1'b1;
    end
    check("bp_rsp_seen", 32'(done), 32'd1);
    bus.req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_valid", 32'(seen_rsp), 32'd1);
      check("bp_data", 32'(seen_data), 32'hC3);
      check("bp_id", 32'(seen_id), 32'd2);
      check("bp_ready", 32'(seen_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    step();
    check("bp_rsp_dropped", 32'(seen_rsp), 32'd0);
    check("bp_regrant", 32'(seen_ready), 32'b1000);
    bus.req_valid = '0;
    repeat (4) step();

    // Reset while a result is held; no late response, requester 0 first.
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      step();
      if (seen_ready != '0) bus.req_valid = '0;
      if (seen_rsp) done = 1'b1;
    end
    check("mid_rsp_seen", 32'(done), 32'd1);
    apply_reset(4'b1111);
    bus.rsp_ready = 1'b1;
    step();
    check("post_reset_wait", 32'(seen_ready), 32'd0);
    step();
    check("post_reset_grant", 32'(seen_ready), 32'b0001);
    repeat (6) step();

    // Random traffic with sticky request valids.
    v = '0;
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          if (seen_ready[i] ? ($urandom_range(1, 0) == 0) : ($urandom_range(9, 0) == 0))
            v[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          v[i] = 1'b1;
        end
      end
      bus.req_valid = v;
      bus.req_op    = 8'($urandom);
      bus.req_a     = 32'($urandom);
      bus.req_b     = 32'($urandom);
      bus.rsp_ready = 1'($urandom_range(1, 0));
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/shared_gate_scheduler.md
SHARED_GATE_SCHEDULER -- requirements
Module: shared_gate_scheduler

Interface
REQ-001 The module SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The module SHALL have parameter W, default 8, operand and result width in bits.
REQ-003 The module SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-006 The module SHALL have port req_ready  output  N_REQ  per-requester accept strobe.
REQ-007 The module SHALL have port req_op  input  2*N_REQ  per-requester opcode, slice [2i+1:2i].
REQ-008 The module SHALL have port req_a  input  W*N_REQ  per-requester operand A, slice [W*i+W-1:W*i].
REQ-009 The module SHALL have port req_b  input  W*N_REQ  per-requester operand B, same slicing.
REQ-010 The module SHALL have port rsp_valid  output  1  result valid.
REQ-011 The module SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 The module SHALL have port rsp_id  output  $clog2(N_REQ)  index of the requester that owns the result.
REQ-013 The module SHALL have port rsp_data  output  W  result.

Function
REQ-014 The block SHALL own one shared W-bit bitwise logic unit built only from 2:1 muxes, with no & | ^ operators: op 00 = A AND B (b ? a : 0), 01 = A OR B (b ? 1 : a), 10 = A XOR B (b ? ~a : a), 11 = A NAND B.
REQ-015 FSM states SHALL be IDLE, EXEC and HOLD.
REQ-016 In IDLE, with any req_valid set, the block SHALL grant exactly one requester by round-robin starting at (last_grant+1) mod N_REQ.
REQ-017 On grant, the block SHALL pulse req_ready[g] high for that cycle only, latch op/a/b/g, and go to EXEC.
REQ-018 A request SHALL transfer only when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-019 req_ready SHALL be all-zero in EXEC and HOLD, and in IDLE when no req_valid is set.
REQ-020 EXEC SHALL last exactly one cycle: register the mux-unit result into rsp_data, set rsp_id = g and rsp_valid = 1, go to HOLD.
REQ-021 Acceptance-to-rsp_valid latency SHALL be 2 cycles.
REQ-022 In HOLD, rsp_valid, rsp_id and rsp_data SHALL stay stable until rsp_ready = 1.
REQ-023 When rsp_ready = 1 in HOLD, the result SHALL transfer, rsp_valid SHALL drop the next cycle, and the FSM SHALL return to IDLE.
REQ-024 Throughput SHALL be one result per 3 cycles maximum, with no overlap between requests.
REQ-025 A requester dropping req_valid before grant SHALL be skipped with no side effect.
REQ-026 Only the accepted requester SHALL update last_grant.
REQ-027 A requester that keeps req_valid high SHALL be served again only after every other active requester has been served (starvation-free).
REQ-028 last_grant SHALL wrap from N_REQ-1 to 0.
REQ-029 rsp_ready high outside HOLD SHALL be ignored.

Reset
REQ-030 While rst_n = 0, the block SHALL immediately, without a clock edge, force state = IDLE, req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, and last_grant = N_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in EXEC or HOLD SHALL discard the pending result, with no response for it after deassertion.
REQ-032 After rst_n rises, the first grant SHALL come no earlier than the next rising clk edge.

Verification
REQ-033 Single request: N_REQ=4, W=8, req_valid=0001, op=00, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=0001 for one cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=8'h30.
REQ-034 Opcode sweep, all 4 ops with a=8'hA5, b=8'h0F -> rsp_data equals 05, AF, AA and FA in turn.
REQ-035 Round-robin: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,... and each req_ready pulses exactly once per 3 cycles.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready stays 0; when rsp_ready=1 the transfer completes and the next grant comes in IDLE.
REQ-037 Reset mid-op: rst_n low during HOLD with rsp_valid=1 -> rsp_valid=0 before the next clock edge, no late response, first post-reset grant goes to requester 0.
REQ-038 Random: 1000 cycles of random req_valid, op, a, b and rsp_ready -> every accepted request gets exactly one correct response, in acceptance order with the correct rsp_id, and a continuously requesting requester never waits more than N_REQ grants.
